// File: rtl/bcd_display_scanner_if.sv
// Channel inputs and digit-scan outputs between the measurement counters,
// the scanner and the 7-segment decoder/anode drivers.
interface bcd_display_scanner_if #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS*IN_W-1:0] value_bus;
  logic [SEL_W-1:0]         chan_sel;
  logic                     blank_lz;
  logic [3:0]               C_Digit;
  logic [DIGITS-1:0]        C_7Seg;
  logic                     frame_start;
  logic                     ovf;

  modport master (
    output value_bus, chan_sel, blank_lz,
    input  C_Digit, C_7Seg, frame_start, ovf
  );

  modport slave (
    input  value_bus, chan_sel, blank_lz,
    output C_Digit, C_7Seg, frame_start, ovf
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Latches a channel count, converts it to BCD by shift-add-3 and scans the
// digits MSB-first onto a one-hot digit enable, with saturation and blanking.
module bcd_display_scanner #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DWELL    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_scanner_if.slave  bus
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BW    = 4 * DIGITS;
  localparam int unsigned CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned DGW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DLW   = (DWELL > 1) ? $clog2(DWELL) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAXV = pow10(DIGITS) - 1;

  typedef enum logic [1:0] {S_LOAD, S_CONVERT, S_SCAN} state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic [DGW-1:0]  dig_q, dig_d;
  logic [DLW-1:0]  dwell_q, dwell_d;
  logic            blank_q, blank_d;
  logic            ovf_q, ovf_d;

  logic [IN_W-1:0] sel_val;
  logic [BW-1:0]   bcd_adj;
  logic [3:0]      nib;
  logic            hi_zero;

  // Out-of-range selects fall through to channel 0.
  always_comb begin
    sel_val = bus.value_bus[0 +: IN_W];
    for (int unsigned k = 1; k < CHANNELS; k++) begin
      if (bus.chan_sel == SEL_W'(k)) sel_val = bus.value_bus[k*IN_W +: IN_W];
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    dig_d   = dig_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_LOAD: begin
        if (64'(sel_val) > MAXV) begin
          bin_d = IN_W'(MAXV);
          ovf_d = 1'b1;
        end else begin
          bin_d = sel_val;
          ovf_d = 1'b0;
        end
        blank_d = bus.blank_lz;
        bcd_d   = '0;
        bit_d   = '0;
        state_d = S_CONVERT;
      end
      S_CONVERT: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        if (bit_q == CW'(IN_W - 1)) begin
          bit_d   = '0;
          dig_d   = DGW'(DIGITS - 1);
          dwell_d = '0;
          state_d = S_SCAN;
        end else begin
          bit_d = bit_q + CW'(1);
        end
      end
      S_SCAN: begin
        if (dwell_q == DLW'(DWELL - 1)) begin
          dwell_d = '0;
          if (dig_q == '0) state_d = S_LOAD;
          else             dig_d   = dig_q - DGW'(1);
        end else begin
          dwell_d = dwell_q + DLW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      dig_q   <= '0;
      dwell_q <= '0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      dig_q   <= dig_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
    end
  end

  // A digit is blanked only when it and every more significant digit are zero.
  always_comb begin
    nib     = bcd_q[4*32'(dig_q) +: 4];
    hi_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i > 32'(dig_q) && bcd_q[4*i +: 4] != 4'd0) hi_zero = 1'b0;
    end
    bus.C_7Seg      = '0;
    bus.C_Digit     = '0;
    bus.frame_start = (state_q == S_LOAD) && !rst;
    bus.ovf         = ovf_q;
    if (state_q == S_SCAN) begin
      bus.C_7Seg  = DIGITS'(1) << dig_q;
      bus.C_Digit = (blank_q && dig_q != '0 && nib == 4'd0 && hi_zero) ? 4'hF : nib;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Two scanner configurations driven with directed and random channel values,
// checked every cycle against a decimal-arithmetic model of the frame.
module tb_bcd_display_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  always #5 clk = ~clk;

  bcd_display_scanner_if #(.IN_W(8), .DIGITS(4), .CHANNELS(2), .SEL_W(1)) ifa ();
  bcd_display_scanner_if #(.IN_W(8), .DIGITS(2), .CHANNELS(3), .SEL_W(2)) ifb ();

  bcd_display_scanner #(.IN_W(8), .DIGITS(4), .CHANNELS(2), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  bcd_display_scanner #(.IN_W(8), .DIGITS(2), .CHANNELS(3), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // {digit enable, digit code} for cycle c of a frame showing value v.
  function automatic logic [11:0] expect_scan(input int unsigned c, input int unsigned in_w,
                                              input int unsigned digits, input int unsigned dwell,
                                              input int unsigned v, input logic blank);
    int unsigned d, dg;
    if (c <= in_w) return 12'h000;
    d  = digits - 1 - (c - in_w - 1) / dwell;
    dg = (v / pow10(d)) % 10;
    if (blank && d > 0 && v < pow10(d)) dg = 15;
    return {8'(1 << d), 4'(dg)};
  endfunction

  int unsigned m_c[2];
  int unsigned m_v[2];
  logic        m_blank[2];
  logic        m_ovf[2];
  logic        m_prev_rst[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_c[i] = 0; m_v[i] = 0; m_blank[i] = 1'b0; m_ovf[i] = 1'b0; m_prev_rst[i] = 1'b1;
    end
  end

  task automatic model_step(input int m, input string nm, input logic fs, input logic [7:0] seg,
                            input logic [3:0] dig, input logic ovf, input int unsigned raw,
                            input logic blank_in, input int unsigned in_w,
                            input int unsigned digits, input int unsigned dwell);
    int unsigned frame;
    int unsigned maxv;
    logic [11:0] e;
    frame = 1 + in_w + digits * dwell;
    maxv  = pow10(digits) - 1;
    if (m_prev_rst[m]) begin
      m_c[m]   = 0;
      m_ovf[m] = 1'b0;
    end
    e = expect_scan(m_c[m], in_w, digits, dwell, m_v[m], m_blank[m]);
    check({nm, ".frame_start"}, 32'(fs), 32'(m_c[m] == 0 && !rst));
    check({nm, ".C_7Seg"}, 32'(seg), 32'(e[11:4]));
    check({nm, ".C_Digit"}, 32'(dig), 32'(e[3:0]));
    check({nm, ".ovf"}, 32'(ovf), 32'(m_ovf[m]));
    if (m_c[m] == 0 && !rst) begin
      m_ovf[m]   = (raw > maxv);
      m_v[m]     = (raw > maxv) ? maxv : raw;
      m_blank[m] = blank_in;
    end
    m_prev_rst[m] = rst;
    m_c[m] = (m_c[m] + 1) % frame;
  endtask

  always @(negedge clk) begin : mon_a
    int unsigned sel, raw;
    sel = 32'(ifa.chan_sel);
    if (sel >= 2) sel = 0;
    raw = 32'(ifa.value_bus >> (8 * sel)) & 32'hFF;
    model_step(0, "A", ifa.frame_start, 8'(ifa.C_7Seg), ifa.C_Digit, ifa.ovf, raw,
               ifa.blank_lz, 8, 4, 4);
  end

  always @(negedge clk) begin : mon_b
    int unsigned sel, raw;
    sel = 32'(ifb.chan_sel);
    if (sel >= 3) sel = 0;
    raw = 32'(ifb.value_bus >> (8 * sel)) & 32'hFF;
    model_step(1, "B", ifb.frame_start, 8'(ifb.C_7Seg), ifb.C_Digit, ifb.ovf, raw,
               ifb.blank_lz, 8, 2, 1);
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Config A: 25-cycle frames; input changes land at cycle 12 of each frame.
  initial begin
    ifa.value_bus = {8'd5, 8'd137};
    ifa.chan_sel  = 1'b0;
    ifa.blank_lz  = 1'b0;
    step(3);
    rst = 1'b0;
    step(12);
    ifa.blank_lz = 1'b1;
    step(25);
    ifa.value_bus = {8'd5, 8'd0};
    step(25);
    ifa.value_bus = {8'd5, 8'd137};
    ifa.blank_lz  = 1'b0;
    step(25);
    ifa.chan_sel = 1'b1;
    step(28);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(50);
    for (int i = 0; i < 14; i++) begin
      step($urandom_range(1, 30));
      ifa.value_bus = 16'($urandom);
      ifa.chan_sel  = 1'($urandom);
      ifa.blank_lz  = 1'($urandom);
    end
    step(30);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Config B: 11-cycle frames, two digits, single-cycle dwell.
  initial begin
    ifb.value_bus = {8'd22, 8'd11, 8'd200};
    ifb.chan_sel  = 2'd0;
    ifb.blank_lz  = 1'b0;
    step(3);
    step(5);
    ifb.value_bus = {8'd22, 8'd11, 8'd42};
    step(11);
    ifb.value_bus = {8'd22, 8'd11, 8'd7};
    ifb.chan_sel  = 2'd3;
    ifb.blank_lz  = 1'b1;
    step(11);
    while (!done) begin
      step($urandom_range(1, 15));
      ifb.value_bus = 24'($urandom);
      ifb.chan_sel  = 2'($urandom);
      ifb.blank_lz  = 1'($urandom);
    end
  end
endmodule
